memctrl_req_seq: RTL and testbench
==================================

// Module: memctrl_req_seq
// PURPOSE
//  Upstream sequencer for MEMCTRL. Accepts valid/ready read/write requests from a bus master,
//  buffers up to 2, and replays each as a one-cycle SRAM-style strobe on MEMCTRL's pins
//  (ADDR/CE/CSB/WEB/OEB/IDATA). For reads it captures ODATA after a fixed latency and returns
//  it on a valid/ready response port. Replaces hand-timed strobe driving in system use.
// PARAMETERS
//  AW      16  address width (matches MEMCTRL ADDR)
//  DW      8   data width (matches MEMCTRL IDATA/ODATA)
//  RD_LAT  2   cycles from read-strobe cycle to ODATA sample; legal 1..7
//  GAP     1   idle cycles inserted after every access; legal 0..7
// PORTS
//  CLK        in   1   clock, all logic on posedge
//  RSTN       in   1   asynchronous active-low reset
//  REQ_VALID  in   1   request present
//  REQ_READY  out  1   request accepted when VALID&READY at posedge
//  REQ_WR     in   1   1=write, 0=read
//  REQ_ADDR   in   AW  request address
//  REQ_WDATA  in   DW  write data (ignored for reads)
//  RSP_VALID  out  1   read data available
//  RSP_READY  in   1   consumer takes RSP_RDATA when VALID&READY
//  RSP_RDATA  out  DW  captured read data
//  ADDR       out  AW  to MEMCTRL ADDR
//  CE         out  1   to MEMCTRL CE, active high
//  CSB        out  1   to MEMCTRL CSB, active low
//  WEB        out  1   to MEMCTRL WEB, active low
//  OEB        out  1   to MEMCTRL OEB, active low
//  IDATA      out  DW  to MEMCTRL IDATA
//  ODATA      in   DW  from MEMCTRL ODATA
//  BUSY       out  1   FIFO non-empty or state != IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: CE=0 CSB=1 WEB=1 OEB=1 ADDR=0 IDATA=0 REQ_READY=0
//    RSP_VALID=0 RSP_RDATA=0 BUSY=0; FIFO flushed, state IDLE. REQ_READY rises first edge after release.
//  - Reset asserted mid-operation: pins return to idle values immediately (async); queued
//    requests and pending response are discarded, no partial strobe resumes.
//  - FIFO 2 deep; push on REQ_VALID&REQ_READY. REQ_READY = registered (next_count<2); push while
//    full never occurs. Simultaneous push+pop allowed; count unchanged.
//  - FSM: IDLE -> STROBE -> (read) WAIT -> GAP -> IDLE; write skips WAIT. GAP=0 skips GAP state.
//    IDLE pops head when FIFO non-empty, except a read head stalls while RSP_VALID=1 (a write
//    head proceeds). Order strictly preserved; no reordering around a stalled read.
//  - STROBE (1 cycle): CE=1 CSB=0; write: WEB=0 OEB=1 IDATA=wdata; read: WEB=1 OEB=0 IDATA=0.
//    ADDR=head address, held unchanged through WAIT and GAP until next STROBE.
//  - WAIT: CE=0 CSB=1 WEB=1 OEB=0 for RD_LAT cycles; ODATA sampled into RSP_RDATA at the edge
//    ending the RD_LAT-th cycle after STROBE; RSP_VALID set same edge.
//  - GAP: CE=0 CSB=1 WEB=1 OEB=1 IDATA=0, GAP cycles, down-counter 3 bits.
//  - RSP_VALID holds with stable RSP_RDATA until RSP_READY; cleared at that edge.
//  - Latency: request accepted at edge N -> STROBE from edge N+1 (FIFO empty, IDLE).
//    Throughput: writes 1 per (1+GAP) cycles; reads 1 per (1+RD_LAT+GAP).
//  - Addresses passed through unmodified; no increment, no wrap logic.
// STRUCTURE
//  - memctrl_pkg: state enum (IDLE,STROBE,WAIT,GAP), request struct {wr,addr,wdata},
//    default AW/DW constants, pin idle-value constants.
//  - Sub-module memctrl_req_fifo: 2-entry synchronous FIFO with registered ready/count.
//  - Top: FSM + latency/gap counters + response register.
// TESTING
//  - Reset: RSTN low 3 cycles -> all pins at idle values, REQ_READY=0, then 1 one edge after release.
//  - Single write 0x0012/0xA5 -> one cycle CE=1 CSB=0 WEB=0 OEB=1 IDATA=0xA5, then GAP idle cycle.
//  - Read 0x0012 with model returning 0xA5 after RD_LAT=2 -> RSP_VALID with RSP_RDATA=0xA5, OEB low 3 cycles.
//  - 4 back-to-back writes, REQ_VALID held -> REQ_READY drops at 2 queued; strobes every 2 cycles, in order.
//  - RSP_READY=0 after read, then read+write queued -> write strobes, second read waits until RSP_READY.
//  - RSTN pulsed during WAIT -> pins idle at once, RSP_VALID never asserts, FIFO empty after release.

Source files
------------

// File: rtl/memctrl_req_seq_pkg.sv
// Shared types and constants for the MEMCTRL request sequencer: FSM states,
// request record, default widths and the idle levels of the MEMCTRL strobe pins.
package memctrl_req_seq_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } req_t;

    localparam logic CE_IDLE  = 1'b0;
    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;
    localparam logic OEB_IDLE = 1'b1;

    // Down-counters run from cycles-1 to zero, so a phase of N cycles loads N-1.
    function automatic logic [2:0] cnt_load(input int cycles);
        return 3'(cycles - 1);
    endfunction

endpackage

// File: rtl/memctrl_req_seq_if.sv
// Request/response handshake bundle between a bus master and the sequencer.
interface memctrl_req_seq_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/memctrl_req_seq_fifo.sv
// Two-entry request FIFO; ready is registered from the post-update occupancy
// so the upstream handshake never sees a combinational path.
module memctrl_req_seq_fifo #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         not_empty,
    output logic         ready,
    output logic [1:0]   next_count
);
    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         ready_r;
    logic [1:0]   next_count_s;

    assign next_count_s = count_r + {1'b0, push} - {1'b0, pop};

    // Storage, pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            ready_r  <= 1'b0;
        end else begin
            count_r <= next_count_s;
            ready_r <= (next_count_s < 2'd2);
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    assign head       = mem_r[rd_ptr_r];
    assign not_empty  = (count_r != 2'd0);
    assign ready      = ready_r;
    assign next_count = next_count_s;

endmodule

// File: rtl/memctrl_req_seq.sv
// Sequencer that replays queued bus requests as single-cycle SRAM strobes on
// the MEMCTRL pins and returns read data through a valid/ready response port.
module memctrl_req_seq
    import memctrl_req_seq_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    memctrl_req_seq_if.slave bus,
    output logic [AW-1:0]    addr,
    output logic             ce,
    output logic             csb,
    output logic             web,
    output logic             oeb,
    output logic [DW-1:0]    idata,
    input  logic [DW-1:0]    odata,
    output logic             busy
);
    localparam int         RW        = 1 + AW + DW;
    localparam logic [2:0] WAIT_LOAD = cnt_load(RD_LAT);
    localparam logic [2:0] GAP_LOAD  = cnt_load(GAP);
    localparam logic       HAS_GAP   = (GAP > 0);

    state_e        state_r, state_next_s, resume_s;
    logic [2:0]    wait_cnt_r, wait_next_s;
    logic [2:0]    gap_cnt_r, gap_next_s;
    logic          op_wr_r;
    logic          push_s, pop_s, end_access_s;
    logic          head_valid_s, fifo_ready_s;
    logic [1:0]    next_count_s;
    logic [RW-1:0] push_data_s, head_s;
    logic          head_wr_s;
    logic [AW-1:0] head_addr_s;
    logic [DW-1:0] head_wdata_s;
    logic          capture_s, rsp_valid_next_s, can_start_s;

    logic [AW-1:0] addr_r, addr_next_s;
    logic          ce_r, ce_next_s, csb_r, csb_next_s;
    logic          web_r, web_next_s, oeb_r, oeb_next_s;
    logic [DW-1:0] idata_r, idata_next_s;
    logic          busy_r, busy_next_s;
    logic          rsp_valid_r;
    logic [DW-1:0] rsp_rdata_r;

    assign push_s      = bus.req_valid & fifo_ready_s;
    assign push_data_s = {bus.req_wr, bus.req_addr, bus.req_wdata};

    memctrl_req_seq_fifo #(.W(RW)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_data  (push_data_s),
        .pop        (pop_s),
        .head       (head_s),
        .not_empty  (head_valid_s),
        .ready      (fifo_ready_s),
        .next_count (next_count_s)
    );

    assign head_wr_s    = head_s[RW-1];
    assign head_addr_s  = head_s[DW +: AW];
    assign head_wdata_s = head_s[DW-1:0];

    // Next state; a read head waits while a response is (or is becoming) pending.
    always_comb begin
        capture_s        = (state_r == ST_WAIT) && (wait_cnt_r == 3'd0);
        rsp_valid_next_s = capture_s | (rsp_valid_r & ~bus.rsp_ready);
        can_start_s      = head_valid_s && (head_wr_s || !rsp_valid_next_s);
        resume_s         = can_start_s ? ST_STROBE : ST_IDLE;
        state_next_s     = state_r;
        wait_next_s      = wait_cnt_r;
        gap_next_s       = gap_cnt_r;
        end_access_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                end_access_s = 1'b1;
                state_next_s = resume_s;
            end
            ST_STROBE: begin
                if (!op_wr_r) begin
                    state_next_s = ST_WAIT;
                    wait_next_s  = WAIT_LOAD;
                end else if (HAS_GAP) begin
                    state_next_s = ST_GAP;
                    gap_next_s   = GAP_LOAD;
                end else begin
                    end_access_s = 1'b1;
                    state_next_s = resume_s;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r != 3'd0) begin
                    wait_next_s = wait_cnt_r - 3'd1;
                end else if (HAS_GAP) begin
                    state_next_s = ST_GAP;
                    gap_next_s   = GAP_LOAD;
                end else begin
                    end_access_s = 1'b1;
                    state_next_s = resume_s;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r != 3'd0) begin
                    gap_next_s = gap_cnt_r - 3'd1;
                end else begin
                    end_access_s = 1'b1;
                    state_next_s = resume_s;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        pop_s = end_access_s & can_start_s;
    end

    // Pin values for the upcoming cycle; ADDR holds until the next strobe.
    always_comb begin
        addr_next_s  = addr_r;
        ce_next_s    = CE_IDLE;
        csb_next_s   = CSB_IDLE;
        web_next_s   = WEB_IDLE;
        oeb_next_s   = OEB_IDLE;
        idata_next_s = {DW{1'b0}};
        case (state_next_s)
            ST_STROBE: begin
                ce_next_s   = 1'b1;
                csb_next_s  = 1'b0;
                addr_next_s = head_addr_s;
                if (head_wr_s) begin
                    web_next_s   = 1'b0;
                    idata_next_s = head_wdata_s;
                end else begin
                    oeb_next_s = 1'b0;
                end
            end
            ST_WAIT: begin
                oeb_next_s = 1'b0;
            end
            default: begin
                ce_next_s = CE_IDLE;
            end
        endcase
        busy_next_s = (next_count_s != 2'd0) || (state_next_s != ST_IDLE);
    end

    // State, counters, pins and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 3'd0;
            gap_cnt_r   <= 3'd0;
            op_wr_r     <= 1'b0;
            addr_r      <= {AW{1'b0}};
            ce_r        <= CE_IDLE;
            csb_r       <= CSB_IDLE;
            web_r       <= WEB_IDLE;
            oeb_r       <= OEB_IDLE;
            idata_r     <= {DW{1'b0}};
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            wait_cnt_r  <= wait_next_s;
            gap_cnt_r   <= gap_next_s;
            if (pop_s) begin
                op_wr_r <= head_wr_s;
            end
            addr_r      <= addr_next_s;
            ce_r        <= ce_next_s;
            csb_r       <= csb_next_s;
            web_r       <= web_next_s;
            oeb_r       <= oeb_next_s;
            idata_r     <= idata_next_s;
            busy_r      <= busy_next_s;
            rsp_valid_r <= rsp_valid_next_s;
            if (capture_s) begin
                rsp_rdata_r <= odata;
            end
        end
    end

    assign addr          = addr_r;
    assign ce            = ce_r;
    assign csb           = csb_r;
    assign web           = web_r;
    assign oeb           = oeb_r;
    assign idata         = idata_r;
    assign busy          = busy_r;
    assign bus.req_ready = fifo_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_memctrl_req_seq.sv
// Directed bench for memctrl_req_seq (RD_LAT=2, GAP=1): a cycle table of
// inputs and expected pins, then a reset-during-read sequence.
module tb_memctrl_req_seq;
    import memctrl_req_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic        ce, csb, web, oeb, busy;
    logic [7:0]  idata, odata;

    memctrl_req_seq_if #(.AW(16), .DW(8)) bus_if ();

    memctrl_req_seq #(.AW(16), .DW(8), .RD_LAT(2), .GAP(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave),
        .addr  (addr),
        .ce    (ce),
        .csb   (csb),
        .web   (web),
        .oeb   (oeb),
        .idata (idata),
        .odata (odata),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        vld;
        req_t        req;
        logic        rrdy;
        logic [7:0]  od;
        logic [15:0] x_addr;
        logic [3:0]  x_pins;
        logic [7:0]  x_idata;
        logic        x_rdy;
        logic        x_rv;
        logic [7:0]  x_rd;
        logic        x_busy;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [3:0] PI  = 4'b0111;  // {ce,csb,web,oeb} idle
    localparam logic [3:0] PSW = 4'b1001;  // write strobe
    localparam logic [3:0] PSR = 4'b1010;  // read strobe
    localparam logic [3:0] PWT = 4'b0110;  // read wait

    task automatic add(input logic r, input logic v, input logic wr, input logic [15:0] a,
                       input logic [7:0] wd, input logic rr, input logic [7:0] od,
                       input logic [15:0] ea, input logic [3:0] p, input logic [7:0] eid,
                       input logic erdy, input logic erv, input logic [7:0] erd, input logic eb);
        vec_t t;
        t.rst_n = r; t.vld = v; t.req.wr = wr; t.req.addr = a; t.req.wdata = wd;
        t.rrdy = rr; t.od = od; t.x_addr = ea; t.x_pins = p; t.x_idata = eid;
        t.x_rdy = erdy; t.x_rv = erv; t.x_rd = erd; t.x_busy = eb;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        bus_if.req_valid = 1'b0; bus_if.req_wr = 1'b0;
        bus_if.req_addr = 16'h0000; bus_if.req_wdata = 8'h00;
        bus_if.rsp_ready = 1'b0; odata = 8'h00;

        // reset held 3 cycles, then release
        for (int i = 0; i < 3; i++) add(1'b0,1'b0,1'b0,16'h0,8'h0,1'b0,8'h0, 16'h0,PI,8'h0,1'b0,1'b0,8'h0,1'b0);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0000,PI ,8'h00,1'b1,1'b0,8'h00,1'b0);
        // single write 0x0012/0xA5
        add(1'b1,1'b1,1'b1,16'h0012,8'hA5,1'b0,8'h00, 16'h0000,PI ,8'h00,1'b1,1'b0,8'h00,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0012,PSW,8'hA5,1'b1,1'b0,8'h00,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0012,PI ,8'h00,1'b1,1'b0,8'h00,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0012,PI ,8'h00,1'b1,1'b0,8'h00,1'b0);
        // read 0x0012; ODATA is 0xA5 only on the sample edge
        add(1'b1,1'b1,1'b0,16'h0012,8'h00,1'b0,8'h00, 16'h0012,PI ,8'h00,1'b1,1'b0,8'h00,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0012,PSR,8'h00,1'b1,1'b0,8'h00,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h33, 16'h0012,PWT,8'h00,1'b1,1'b0,8'h00,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h5C, 16'h0012,PWT,8'h00,1'b1,1'b0,8'h00,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'hA5, 16'h0012,PI ,8'h00,1'b1,1'b1,8'hA5,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0012,PI ,8'h00,1'b1,1'b1,8'hA5,1'b0);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h00, 16'h0012,PI ,8'h00,1'b1,1'b0,8'hA5,1'b0);
        // four back-to-back writes with valid held
        add(1'b1,1'b1,1'b1,16'h0100,8'h10,1'b0,8'h00, 16'h0012,PI ,8'h00,1'b1,1'b0,8'hA5,1'b1);
        add(1'b1,1'b1,1'b1,16'h0101,8'h11,1'b0,8'h00, 16'h0100,PSW,8'h10,1'b1,1'b0,8'hA5,1'b1);
        add(1'b1,1'b1,1'b1,16'h0102,8'h12,1'b0,8'h00, 16'h0100,PI ,8'h00,1'b0,1'b0,8'hA5,1'b1);
        add(1'b1,1'b1,1'b1,16'h0103,8'h13,1'b0,8'h00, 16'h0101,PSW,8'h11,1'b1,1'b0,8'hA5,1'b1);
        add(1'b1,1'b1,1'b1,16'h0103,8'h13,1'b0,8'h00, 16'h0101,PI ,8'h00,1'b0,1'b0,8'hA5,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0102,PSW,8'h12,1'b1,1'b0,8'hA5,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0102,PI ,8'h00,1'b1,1'b0,8'hA5,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0103,PSW,8'h13,1'b1,1'b0,8'hA5,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0103,PI ,8'h00,1'b1,1'b0,8'hA5,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0103,PI ,8'h00,1'b1,1'b0,8'hA5,1'b0);
        // read left unconsumed, then write + read queued behind it
        add(1'b1,1'b1,1'b0,16'h0200,8'h00,1'b0,8'h00, 16'h0103,PI ,8'h00,1'b1,1'b0,8'hA5,1'b1);
        add(1'b1,1'b1,1'b1,16'h0300,8'h77,1'b0,8'h00, 16'h0200,PSR,8'h00,1'b1,1'b0,8'hA5,1'b1);
        add(1'b1,1'b1,1'b0,16'h0400,8'h00,1'b0,8'h00, 16'h0200,PWT,8'h00,1'b0,1'b0,8'hA5,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0200,PWT,8'h00,1'b0,1'b0,8'hA5,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h3C, 16'h0200,PI ,8'h00,1'b0,1'b1,8'h3C,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0300,PSW,8'h77,1'b1,1'b1,8'h3C,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0300,PI ,8'h00,1'b1,1'b1,8'h3C,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0300,PI ,8'h00,1'b1,1'b1,8'h3C,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0300,PI ,8'h00,1'b1,1'b1,8'h3C,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h00, 16'h0400,PSR,8'h00,1'b1,1'b0,8'h3C,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0400,PWT,8'h00,1'b1,1'b0,8'h3C,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0400,PWT,8'h00,1'b1,1'b0,8'h3C,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h99, 16'h0400,PI ,8'h00,1'b1,1'b1,8'h99,1'b1);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b1,8'h00, 16'h0400,PI ,8'h00,1'b1,1'b0,8'h99,1'b0);
        add(1'b1,1'b0,1'b0,16'h0000,8'h00,1'b0,8'h00, 16'h0400,PI ,8'h00,1'b1,1'b0,8'h99,1'b0);

        @(negedge clk);
        for (int k = 0; k < vecs.size(); k++) begin
            rst_n            = vecs[k].rst_n;
            bus_if.req_valid = vecs[k].vld;
            bus_if.req_wr    = vecs[k].req.wr;
            bus_if.req_addr  = vecs[k].req.addr;
            bus_if.req_wdata = vecs[k].req.wdata;
            bus_if.rsp_ready = vecs[k].rrdy;
            odata            = vecs[k].od;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", k),
                  {addr, ce, csb, web, oeb, idata, bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_rdata, busy},
                  {vecs[k].x_addr, vecs[k].x_pins, vecs[k].x_idata, vecs[k].x_rdy, vecs[k].x_rv,
                   vecs[k].x_rd, vecs[k].x_busy});
        end

        // reset pulsed while a read sits in WAIT with a write queued behind it
        bus_if.req_valid = 1'b1; bus_if.req_wr = 1'b0; bus_if.req_addr = 16'h0500;
        @(posedge clk); @(negedge clk);
        bus_if.req_wr = 1'b1; bus_if.req_addr = 16'h0600; bus_if.req_wdata = 8'h42;
        @(posedge clk); @(negedge clk);
        check("rd_strobe", {ce, oeb, addr}, {1'b1, 1'b0, 16'h0500});
        bus_if.req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("in_wait", {ce, csb, oeb, busy}, 4'b0101);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_pins",
              {addr, ce, csb, web, oeb, idata, bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_rdata, busy},
              {16'h0000, 4'b0111, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
        odata = 8'hEE;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rdy_after_release", {bus_if.req_ready, busy, bus_if.rsp_valid}, 3'b100);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            if (ce || bus_if.rsp_valid || busy) bad++;
        end
        check("no_resume_after_rst", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
